// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse train controller.
//   state_e    : FSM state encoding (IDLE, HIGH, LOW, DONE)
//   CNT_W_DEF  : default width of the high/low length fields
//   NUM_W_DEF  : default width of the pulse count field
package pulse_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int NUM_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/start_edge_det.sv
// Rising-edge detector for the start trigger.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   sig_in   : level input to watch
//   rise_out : 1 in the cycle where sig_in=1 and the previous sample was 0
module start_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise_out
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    // History resets to 1 so a trigger held high through reset release
    // is not mistaken for a fresh edge.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= 1'b1;
        else     sig_q <= sig_d;
    end

    assign rise_out = sig_in & ~sig_q;

endmodule

// File: rtl/pulse_train_ctrl.sv
// Pulse train generator: on an accepted start edge, emits num_pulses
// pulses of high_len cycles separated by low_len-cycle gaps, then a
// one-cycle done strobe. abort ends an active train early.
//   clk, rst            : clock, asynchronous active-high reset
//   start, abort        : trigger (rising edge) and abort level
//   high_len, low_len   : phase lengths in cycles (0 behaves as 1)
//   num_pulses          : pulses per train (0 gives an immediate done)
//   pulse_out, busy     : registered train output and in-progress flag
//   done, aborted       : end-of-train strobe and its abort qualifier
//   pulse_idx           : 0-based index of the current pulse
module pulse_train_ctrl
    import pulse_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NUM_W = NUM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [NUM_W-1:0] pulse_idx
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hl_q, hl_d;
    logic [CNT_W-1:0] ll_q, ll_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] idx_q, idx_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             start_rise;
    logic [CNT_W-1:0] hl_eff, ll_eff;

    start_edge_det u_start_edge_det (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (start),
        .rise_out (start_rise)
    );

    assign hl_eff = (high_len == '0) ? CNT_ONE : high_len;
    assign ll_eff = (low_len  == '0) ? CNT_ONE : low_len;

    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hl_d      = hl_q;
        ll_d      = ll_q;
        num_d     = num_q;
        idx_d     = idx_q;
        aborted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort in the same cycle as an edge swallows the edge
                if (start_rise && !abort) begin
                    hl_d  = hl_eff;
                    ll_d  = ll_eff;
                    num_d = num_pulses;
                    if (num_pulses != '0) begin
                        state_d = ST_HIGH;
                        cnt_d   = hl_eff;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (cnt_q == CNT_ONE) begin
                    if (idx_q == num_q - NUM_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOW;
                        cnt_d   = ll_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_HIGH;
                    cnt_d   = hl_q;
                    idx_d   = idx_q + NUM_ONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of the next-state decode, so
        // they line up with the state they describe.
        pulse_d = (state_d == ST_HIGH);
        busy_d  = (state_d == ST_HIGH) || (state_d == ST_LOW);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hl_q      <= '0;
            ll_q      <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hl_q      <= hl_d;
            ll_q      <= ll_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign pulse_idx = idx_q;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Self-checking bench for pulse_train_ctrl: table of train vectors whose
// expected per-cycle outputs are queued at start and popped each cycle,
// plus hand-written reset and abort/start corner sequences.
module tb_pulse_train_ctrl;

    localparam int CNT_W = 8;
    localparam int NUM_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [NUM_W-1:0] num_pulses;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [NUM_W-1:0] pulse_idx;

    pulse_train_ctrl #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .high_len   (high_len),
        .low_len    (low_len),
        .num_pulses (num_pulses),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pulse_idx  (pulse_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pulse;
        logic             busy;
        logic             done;
        logic             aborted;
        logic [NUM_W-1:0] idx;
    } obs_t;

    // abort_k / stray_k / chg_k: train cycle at which abort is raised, a
    // fresh start edge is attempted, or high_len is changed (-1 = never)
    typedef struct {
        int hl;
        int ll;
        int n;
        int abort_k;
        int stray_k;
        int chg_k;
        int chg_hl;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];
    obs_t exp_q [$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [NUM_W-1:0] idx_hold;

    function automatic obs_t mk(input logic p, input logic b, input logic d,
                                input logic a, input int idx);
        obs_t o;
        o.pulse   = p;
        o.busy    = b;
        o.done    = d;
        o.aborted = a;
        o.idx     = idx[NUM_W-1:0];
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(pulse_out, busy, done, aborted, int'(pulse_idx));
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got pulse=%0b busy=%0b done=%0b aborted=%0b idx=%0d, want pulse=%0b busy=%0b done=%0b aborted=%0b idx=%0d",
                     name, act.pulse, act.busy, act.done, act.aborted, act.idx,
                     exp.pulse, exp.busy, exp.done, exp.aborted, exp.idx);
        end
    endtask

    // Reference train: h high cycles per pulse, l low cycles between
    // pulses, none after the last; then one done cycle and one idle cycle.
    task automatic build_trace(input vec_t v);
        obs_t busyq [$];
        int   h;
        int   l;
        int   len;
        logic abrt;
        logic [NUM_W-1:0] last;
        h = (v.hl == 0) ? 1 : v.hl;
        l = (v.ll == 0) ? 1 : v.ll;
        for (int p = 0; p < v.n; p++) begin
            for (int c = 0; c < h; c++) busyq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, p));
            if (p < v.n - 1)
                for (int c = 0; c < l; c++) busyq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, p));
        end
        abrt = (v.abort_k >= 0) && (v.abort_k < busyq.size());
        len  = abrt ? v.abort_k + 1 : busyq.size();
        for (int i = 0; i < len; i++) exp_q.push_back(busyq[i]);
        last = (len > 0) ? busyq[len-1].idx : idx_hold;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, abrt, int'(last)));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, int'(last)));
        idx_hold = last;
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        obs_t e;
        int   j;
        @(negedge clk);
        start      = 1'b0;
        abort      = 1'b0;
        high_len   = CNT_W'(v.hl);
        low_len    = CNT_W'(v.ll);
        num_pulses = NUM_W'(v.n);
        @(negedge clk);
        check($sformatf("v%0d_idle_pre", vi), observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, int'(idx_hold)));
        start = 1'b1;
        build_trace(v);
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d_c%0d", vi, j), observe(), e);
            if (j == 0)          start = 1'b0;
            if (j == v.stray_k)  start = 1'b1;
            abort = (j == v.abort_k);
            if (j == v.chg_k)    high_len = CNT_W'(v.chg_hl);
            j++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            hl ll  n abort stray chg chg_hl
        vecs[0] = '{3, 2, 3, -1, -1, -1, 0};  // basic 3x(3/2)
        vecs[1] = '{5, 1, 0, -1, -1, -1, 0};  // zero pulses
        vecs[2] = '{0, 0, 2, -1, -1, -1, 0};  // zero lengths act as 1
        vecs[3] = '{2, 3, 4,  5,  3, -1, 0};  // abort in 2nd HIGH, stray edge in LOW
        vecs[4] = '{3, 2, 3, -1, -1,  1, 7};  // high_len change mid-train
        vecs[5] = '{1, 1, 1, -1,  1, -1, 0};  // edge during DONE dropped
        vecs[6] = '{4, 0, 2,  4, -1, -1, 0};  // abort in LOW
        vecs[7] = '{1, 2, 5, -1, -1, -1, 0};  // longer train

        rst        = 1'b1;
        start      = 1'b1;
        abort      = 1'b0;
        high_len   = '0;
        low_len    = '0;
        num_pulses = '0;
        idx_hold   = '0;

        repeat (2) @(negedge clk);
        check("reset_state", observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        num_pulses = NUM_W'(2);
        high_len   = CNT_W'(2);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("start_held_thru_rst", observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end
        start = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // reset in the middle of a LOW phase of pulse 1
        @(negedge clk);
        high_len   = CNT_W'(1);
        low_len    = CNT_W'(4);
        num_pulses = NUM_W'(3);
        @(negedge clk);
        start = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_rst_low", observe(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1));
        #2 rst = 1'b1;
        #1 check("rst_mid_low_async", observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        check("rst_held", observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        start = 1'b0;
        rst   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_done", observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        end
        idx_hold = '0;

        // abort and start edge in the same IDLE cycle: edge is lost
        high_len   = CNT_W'(2);
        low_len    = CNT_W'(2);
        num_pulses = NUM_W'(2);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_start_same", observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, int'(idx_hold)));
        abort = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("no_retrigger", observe(), mk(1'b0, 1'b0, 1'b0, 1'b0, int'(idx_hold)));
        end
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pulse_train_ctrl.md
PULSE_TRAIN_CTRL -- requirements
Module: pulse_train_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, setting the width of the high/low length fields.
REQ-002 The block SHALL have parameter NUM_W, default 8, setting the width of the pulse count field.
REQ-003 Port clk, input, 1: the single clock, with all state updated on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port start, input, 1: trigger level; only its rising edge requests a train.
REQ-006 Port abort, input, 1: level; terminates an active train.
REQ-007 Port high_len, input, CNT_W: pulse high time in clk cycles.
REQ-008 Port low_len, input, CNT_W: gap between pulses in clk cycles.
REQ-009 Port num_pulses, input, NUM_W: number of pulses in the train.
REQ-010 Port pulse_out, output, 1: generated pulse train, registered.
REQ-011 Port busy, output, 1: high while a train is in progress.
REQ-012 Port done, output, 1: one-cycle strobe at the end of a train.
REQ-013 Port aborted, output, 1: valid with done; 1 if the train was terminated by abort.
REQ-014 Port pulse_idx, output, NUM_W: 0-based index of the current pulse; holds its last value in IDLE.

Function
REQ-015 The block SHALL detect a start rising edge as start=1 in cycle t with start=0 sampled in cycle t-1.
REQ-016 A start edge SHALL be accepted only in IDLE; an edge seen in HIGH, LOW or DONE SHALL be dropped, not queued.
REQ-017 On acceptance the block SHALL latch high_len, low_len and num_pulses; later input changes SHALL have no effect until the next acceptance.
REQ-018 A high_len or low_len of 0 SHALL be treated as 1.
REQ-019 The FSM SHALL have states IDLE, HIGH, LOW and DONE.
REQ-020 IDLE->HIGH SHALL occur on an accepted edge with latched num_pulses>0; pulse_out SHALL be 1 from cycle t+1.
REQ-021 IDLE->DONE SHALL occur on an accepted edge with num_pulses=0; no pulse is emitted and done SHALL assert at t+1.
REQ-022 HIGH SHALL last exactly high_len cycles with pulse_out=1, then go to LOW, or to DONE if it was the last pulse.
REQ-023 LOW SHALL last exactly low_len cycles with pulse_out=0; it then goes to HIGH and pulse_idx increments.
REQ-024 No LOW phase SHALL follow the last pulse.
REQ-025 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-026 busy SHALL be 1 exactly in HIGH and LOW.
REQ-027 When abort=1 in HIGH or LOW, the next cycle SHALL be DONE with pulse_out=0 and aborted=1.
REQ-028 When abort and an accepted start edge occur in the same IDLE cycle, abort SHALL win and the edge SHALL be dropped.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 The phase counter SHALL count down from the latched length to 1 with no wrap; num_pulses = 2^NUM_W-1 SHALL be supported.

Reset
REQ-031 While rst=1, the FSM SHALL be in IDLE and pulse_out, busy, done, aborted and pulse_idx SHALL be 0.
REQ-032 The start edge history register SHALL reset to 1, so that start held high through reset release does not trigger a train.
REQ-033 rst asserted mid-train SHALL drop pulse_out the same cycle, asynchronously, with no done strobe.

Structure
REQ-034 The FSM state encoding SHALL be defined in the shared package pulse_pkg; CNT_W and NUM_W defaults SHALL also be defined there.
REQ-035 Start edge detection SHALL be a sub-module start_edge_det with ports clk, rst, sig_in and rise_out.

Verification
REQ-036 high_len=3, low_len=2, num_pulses=3, start edge -> pulse_out = 111 00 111 00 111, then done=1 for one cycle, aborted=0, pulse_idx ending at 2.
REQ-037 num_pulses=0 -> done=1 for one cycle at t+1; pulse_out and busy stay 0.
REQ-038 high_len=0, low_len=0, num_pulses=2 -> pulse_out = 1 0 1, then done.
REQ-039 abort during the second HIGH of a 4-pulse train -> pulse_out=0 and done=1, aborted=1 next cycle; a start edge during that train is ignored.
REQ-040 start held high across rst release -> no train; rst mid-LOW -> all outputs 0 immediately.
REQ-041 Changing high_len from 3 to 7 mid-train -> the remaining pulses keep a width of 3.
